// File: rtl/seq_chk_pkg.sv
// -----------------------------------------------------------------------------
// seq_chk_pkg
// Shared types and helpers for the multi-channel sequence checker
// (seq_window_checker / seq_chk_chan).
//   chk_state_e : per-channel FSM state (IDLE, WAIT)
//   popcount    : number of set bits in a vector of up to 32 bits
//   sat_add     : unsigned add that clamps at a caller-supplied maximum
// -----------------------------------------------------------------------------
package seq_chk_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } chk_state_e;

  // Counts set bits; callers zero-extend narrower vectors to 32 bits.
  function automatic logic [5:0] popcount(input logic [31:0] v);
    logic [5:0] cnt;
    cnt = '0;
    for (int i = 0; i < 32; i++) begin
      cnt = cnt + {5'd0, v[i]};
    end
    return cnt;
  endfunction

  // Operands are 64 bits wide so that cur + inc cannot overflow for any
  // supported counter width; the result never exceeds max_val.
  function automatic logic [63:0] sat_add(input logic [63:0] cur,
                                          input logic [63:0] inc,
                                          input logic [63:0] max_val);
    logic [63:0] sum;
    sum = cur + inc;
    return (sum > max_val) ? max_val : sum;
  endfunction

endpackage

// File: rtl/seq_chk_chan.sv
// -----------------------------------------------------------------------------
// seq_chk_chan
// One channel of the a ##[MIN_DLY:MAX_DLY] b checker: a two-state FSM, the
// delay counter and (optionally) the start-cycle latch.
// Optional feature macro: SEQ_CHK_TIMESTAMP_EN (adds TS_W, cyc, start_ts).
//
// Ports:
//   clk      in  sampling clock, rising edge
//   rst      in  asynchronous active-high reset
//   en       in  global check enable
//   a        in  trigger
//   b        in  expected response
//   cyc      in  free-running cycle count        (timestamp build only)
//   start_ts out cycle of the current attempt's trigger (timestamp build only)
//   busy     out attempt in flight
//   pass     out registered one-cycle pass pulse
//   fail     out registered one-cycle fail pulse
//   fail_nxt out unregistered fail decision for this edge (feeds err_cnt)
// -----------------------------------------------------------------------------
module seq_chk_chan
  import seq_chk_pkg::*;
#(
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 8
`ifdef SEQ_CHK_TIMESTAMP_EN
  ,
  parameter int TS_W    = 32
`endif
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic            a,
  input  logic            b,
`ifdef SEQ_CHK_TIMESTAMP_EN
  input  logic [TS_W-1:0] cyc,
  output logic [TS_W-1:0] start_ts,
`endif
  output logic            busy,
  output logic            pass,
  output logic            fail,
  output logic            fail_nxt
);

  localparam int DLY_W = $clog2(MAX_DLY + 1);
  localparam logic [DLY_W-1:0] MIN_K = DLY_W'(MIN_DLY);
  localparam logic [DLY_W-1:0] MAX_K = DLY_W'(MAX_DLY);
  localparam logic [DLY_W-1:0] ONE_K = DLY_W'(1);

  chk_state_e       r_state;
  chk_state_e       w_state_nxt;
  logic [DLY_W-1:0] r_dly;
  logic [DLY_W-1:0] w_dly_nxt;
  logic             r_pass;
  logic             r_fail;
  logic             w_pass_nxt;
  logic             w_fail_nxt;
  logic             w_load;

  // State register: FSM state, delay counter and the registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_dly   <= '0;
      r_pass  <= 1'b0;
      r_fail  <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking (<=) so every register
      // samples the pre-edge values; combinational blocks use blocking (=).
      r_state <= w_state_nxt;
      r_dly   <= w_dly_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
    end
  end

  // Output decode: resolve the attempt using the delay value k held now.
  // Because dly never exceeds MAX_DLY, k >= MIN_DLY is the whole window test.
  always_comb begin
    // NOTE: every combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    w_pass_nxt = 1'b0;
    w_fail_nxt = 1'b0;
    if (en && (r_state == WAIT)) begin
      if ((r_dly >= MIN_K) && b) begin
        w_pass_nxt = 1'b1;
      end else if ((r_dly == MAX_K) && !b) begin
        w_fail_nxt = 1'b1;
      end
    end
  end

  // Next-state logic. A trigger on the resolving edge re-arms immediately,
  // giving back-to-back attempts with no idle gap.
  always_comb begin
    w_state_nxt = r_state;
    w_dly_nxt   = r_dly;
    w_load      = 1'b0;
    if (!en) begin
      w_state_nxt = IDLE;
      w_dly_nxt   = '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          // b on the trigger edge is deliberately not looked at.
          if (a) begin
            w_state_nxt = WAIT;
            w_dly_nxt   = ONE_K;
            w_load      = 1'b1;
          end
        end
        WAIT: begin
          if (w_pass_nxt || w_fail_nxt) begin
            if (a) begin
              w_state_nxt = WAIT;
              w_dly_nxt   = ONE_K;
              w_load      = 1'b1;
            end else begin
              w_state_nxt = IDLE;
              w_dly_nxt   = '0;
            end
          end else begin
            w_dly_nxt = r_dly + ONE_K;
          end
        end
        default: begin
          w_state_nxt = IDLE;
          w_dly_nxt   = '0;
        end
      endcase
    end
  end

`ifdef SEQ_CHK_TIMESTAMP_EN
  logic [TS_W-1:0] r_start;

  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the start latch is cleared on reset like all other state, so a
    // fail_ts read right after reset is a defined 0 rather than stale data.
    if (rst) begin
      r_start <= '0;
    end else if (w_load) begin
      r_start <= cyc;
    end
  end

  assign start_ts = r_start;
`else
  // Without timestamps the load strobe has no consumer.
  logic w_load_unused;
  assign w_load_unused = w_load;
`endif

  assign busy     = (r_state == WAIT);
  assign pass     = r_pass;
  assign fail     = r_fail;
  assign fail_nxt = w_fail_nxt;

endmodule

// File: rtl/seq_window_checker.sv
// -----------------------------------------------------------------------------
// seq_window_checker
// NCH independent checkers for the property a ##[MIN_DLY:MAX_DLY] b, with a
// saturating failure counter and an optional failure start-cycle timestamp.
// Optional feature macro: SEQ_CHK_TIMESTAMP_EN (adds cyc counter and fail_ts).
//
// Ports:
//   clk     in  sampling clock, rising edge
//   rst     in  asynchronous active-high reset
//   en      in  global check enable (0: all channels return to IDLE)
//   a       in  [NCH]   per-channel trigger
//   b       in  [NCH]   per-channel expected response
//   busy    out [NCH]   attempt in flight
//   pass    out [NCH]   one-cycle pulse on success
//   fail    out [NCH]   one-cycle pulse on timeout
//   err_cnt out [CNT_W] total failures, saturating
//   fail_ts out [TS_W]  start cycle of most recent failure (timestamp build)
// -----------------------------------------------------------------------------
module seq_window_checker
  import seq_chk_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int MIN_DLY = 1,
  parameter int MAX_DLY = 8,
  parameter int CNT_W   = 16,
  parameter int TS_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [NCH-1:0]   a,
  input  logic [NCH-1:0]   b,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   pass,
  output logic [NCH-1:0]   fail,
  output logic [CNT_W-1:0] err_cnt
`ifdef SEQ_CHK_TIMESTAMP_EN
  ,
  output logic [TS_W-1:0]  fail_ts
`endif
);

  // Elaboration-time parameter checks.
  if (MIN_DLY < 1) begin : g_bad_min
    $error("seq_window_checker: MIN_DLY must be >= 1");
  end
  if ((MAX_DLY < MIN_DLY) || (MAX_DLY > 255)) begin : g_bad_max
    $error("seq_window_checker: MAX_DLY must be in MIN_DLY..255");
  end
  if ((NCH < 1) || (NCH > 32)) begin : g_bad_nch
    $error("seq_window_checker: NCH must be in 1..32");
  end
  if ((CNT_W < 1) || (CNT_W > 63) || (TS_W < 1) || (TS_W > 64)) begin : g_bad_w
    $error("seq_window_checker: CNT_W must be 1..63 and TS_W 1..64");
  end

  localparam logic [63:0] CNT_MAX = (64'd1 << CNT_W) - 64'd1;

  logic [NCH-1:0]   w_fail_nxt;
  logic [CNT_W-1:0] r_err_cnt;

`ifdef SEQ_CHK_TIMESTAMP_EN
  logic [TS_W-1:0] r_cyc;
  logic [TS_W-1:0] r_fail_ts;
  logic [TS_W-1:0] w_ts_sel;
  logic [TS_W-1:0] w_start [NCH];
`endif

  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    seq_chk_chan #(
      .MIN_DLY (MIN_DLY),
      .MAX_DLY (MAX_DLY)
`ifdef SEQ_CHK_TIMESTAMP_EN
      ,
      .TS_W    (TS_W)
`endif
    ) u_chan (
      .clk      (clk),
      .rst      (rst),
      .en       (en),
      .a        (a[gi]),
      .b        (b[gi]),
`ifdef SEQ_CHK_TIMESTAMP_EN
      .cyc      (r_cyc),
      .start_ts (w_start[gi]),
`endif
      .busy     (busy[gi]),
      .pass     (pass[gi]),
      .fail     (fail[gi]),
      .fail_nxt (w_fail_nxt[gi])
    );
  end

  // Failures are counted from the same-edge decisions so the count lands in
  // the cycle the fail pulses become visible.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_cnt <= '0;
    end else begin
      r_err_cnt <= CNT_W'(sat_add(64'(r_err_cnt),
                                  64'(popcount(32'(w_fail_nxt))),
                                  CNT_MAX));
    end
  end

  assign err_cnt = r_err_cnt;

`ifdef SEQ_CHK_TIMESTAMP_EN
  // Lowest-index failing channel wins: scan from the top so the last hit
  // (lowest index) is the one that sticks.
  always_comb begin
    w_ts_sel = r_fail_ts;
    for (int i = NCH - 1; i >= 0; i--) begin
      if (w_fail_nxt[i]) begin
        w_ts_sel = w_start[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cyc     <= '0;
      r_fail_ts <= '0;
    end else begin
      r_cyc     <= r_cyc + TS_W'(1);
      r_fail_ts <= w_ts_sel;
    end
  end

  assign fail_ts = r_fail_ts;

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NCH; i++) begin
        if (w_fail_nxt[i]) begin
          $display("[%0d] ch=%0d fail started=%0d", r_cyc, i, w_start[i]);
        end
      end
    end
  end
`endif
`endif

endmodule

// File: tb/tb_seq_window_checker.sv
// -----------------------------------------------------------------------------
// tb_seq_window_checker
// Two checker instances share the same stimulus: u_dut0 with default
// parameters and u_dut1 with MIN_DLY=3, MAX_DLY=5, CNT_W=2 (saturation).
// Expected outputs come from an attempt model that tracks each open
// attempt by the absolute edge number of its trigger.
// -----------------------------------------------------------------------------
module tb_seq_window_checker;

  logic       clk;
  logic       rst;
  logic       en;
  logic [3:0] a;
  logic [3:0] b;

  logic [3:0]  busy0, pass0, fail0;
  logic [15:0] err0;
  logic [3:0]  busy1, pass1, fail1;
  logic [1:0]  err1;
`ifdef SEQ_CHK_TIMESTAMP_EN
  logic [31:0] ts0, ts1;
`endif

  seq_window_checker #(
    .NCH(4), .MIN_DLY(1), .MAX_DLY(8), .CNT_W(16), .TS_W(32)
  ) u_dut0 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .busy(busy0), .pass(pass0), .fail(fail0), .err_cnt(err0)
`ifdef SEQ_CHK_TIMESTAMP_EN
    , .fail_ts(ts0)
`endif
  );

  seq_window_checker #(
    .NCH(4), .MIN_DLY(3), .MAX_DLY(5), .CNT_W(2), .TS_W(32)
  ) u_dut1 (
    .clk(clk), .rst(rst), .en(en), .a(a), .b(b),
    .busy(busy1), .pass(pass1), .fail(fail1), .err_cnt(err1)
`ifdef SEQ_CHK_TIMESTAMP_EN
    , .fail_ts(ts1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state, index m selects the instance.
  int unsigned mn   [2] = '{1, 3};
  int unsigned mx   [2] = '{8, 5};
  int unsigned cmax [2] = '{65535, 3};
  bit          open_q [2][4];
  int unsigned st     [2][4];
  int unsigned cyc_n;
  logic [3:0]  e_busy [2];
  logic [3:0]  e_pass [2];
  logic [3:0]  e_fail [2];
  int unsigned e_err  [2];
  int unsigned e_ts   [2];

  logic [3:0] ra, rb;
  logic       ren;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    cyc_n = 0;
    for (int m = 0; m < 2; m++) begin
      e_busy[m] = '0;
      e_pass[m] = '0;
      e_fail[m] = '0;
      e_err[m]  = 0;
      e_ts[m]   = 0;
      for (int i = 0; i < 4; i++) begin
        open_q[m][i] = 1'b0;
        st[m][i]     = 0;
      end
    end
  endtask

  // One sampling edge: cyc_n is the number of edges seen since reset.
  task automatic model_edge();
    for (int m = 0; m < 2; m++) begin
      int unsigned nfail;
      bit          found;
      nfail     = 0;
      found     = 1'b0;
      e_pass[m] = '0;
      e_fail[m] = '0;
      for (int i = 0; i < 4; i++) begin
        int unsigned age;
        if (!en) begin
          open_q[m][i] = 1'b0;
        end else if (open_q[m][i]) begin
          age = cyc_n - st[m][i];
          if (age >= mn[m] && b[i]) begin
            e_pass[m][i] = 1'b1;
          end else if (age == mx[m] && !b[i]) begin
            e_fail[m][i] = 1'b1;
            nfail++;
            if (!found) begin
              e_ts[m] = st[m][i];
              found   = 1'b1;
            end
          end
          if (e_pass[m][i] || e_fail[m][i]) begin
            open_q[m][i] = a[i];
            st[m][i]     = cyc_n;
          end
        end else if (a[i]) begin
          open_q[m][i] = 1'b1;
          st[m][i]     = cyc_n;
        end
        e_busy[m][i] = open_q[m][i];
      end
      e_err[m] = (e_err[m] + nfail > cmax[m]) ? cmax[m] : e_err[m] + nfail;
    end
    cyc_n++;
  endtask

  task automatic check_all(input string tag);
    check({tag, "_busy0"}, 32'(busy0), 32'(e_busy[0]));
    check({tag, "_pass0"}, 32'(pass0), 32'(e_pass[0]));
    check({tag, "_fail0"}, 32'(fail0), 32'(e_fail[0]));
    check({tag, "_err0"},  32'(err0),  e_err[0]);
    check({tag, "_busy1"}, 32'(busy1), 32'(e_busy[1]));
    check({tag, "_pass1"}, 32'(pass1), 32'(e_pass[1]));
    check({tag, "_fail1"}, 32'(fail1), 32'(e_fail[1]));
    check({tag, "_err1"},  32'(err1),  e_err[1]);
`ifdef SEQ_CHK_TIMESTAMP_EN
    check({tag, "_ts0"}, ts0, e_ts[0]);
    check({tag, "_ts1"}, ts1, e_ts[1]);
`endif
  endtask

  // Inputs change 1 time unit after an edge; outputs are sampled 1 unit after.
  task automatic step(input string tag, input logic e, input logic [3:0] aa, input logic [3:0] bb);
    en = e;
    a  = aa;
    b  = bb;
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle(input string tag, input int n);
    for (int k = 0; k < n; k++) step(tag, 1'b1, 4'b0000, 4'b0000);
  endtask

  // Reset asserted mid-cycle: outputs must clear before the next edge.
  task automatic async_reset(input string tag);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check_all(tag);
    check({tag, "_busy0_now"}, 32'(busy0), 32'd0);
    #2;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    en  = 1'b0;
    a   = '0;
    b   = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 1'b0;

    // Pass at delay 3 (inside both windows).
    step("t1", 1'b1, 4'b0001, 4'b0000);
    idle("t1", 2);
    step("t1", 1'b1, 4'b0000, 4'b0001);
    check("t1_pass0_plan", 32'(pass0), 32'h1);
    check("t1_err0_plan", 32'(err0), 32'h0);
    idle("t1", 2);

    // Unanswered trigger: default instance fails MAX_DLY edges later.
    step("t2", 1'b1, 4'b0010, 4'b0000);
    idle("t2", 8);
    check("t2_fail0_plan", 32'(fail0), 32'h2);
    check("t2_err0_plan", 32'(err0), 32'h1);
    idle("t2", 1);

    // b at delay 2 (ignored by MIN_DLY=3) then delay 3.
    step("t3", 1'b1, 4'b0100, 4'b0000);
    step("t3", 1'b1, 4'b0000, 4'b0000);
    step("t3", 1'b1, 4'b0000, 4'b0100);
    step("t3", 1'b1, 4'b0000, 4'b0100);
    check("t3_pass1_plan", 32'(pass1), 32'h4);
    idle("t3", 1);

    // b only at delay 6: short window fails at 5, default passes at 6.
    step("t3b", 1'b1, 4'b1000, 4'b0000);
    idle("t3b", 5);
    check("t3b_fail1_plan", 32'(fail1), 32'h8);
    step("t3b", 1'b1, 4'b0000, 4'b1000);
    check("t3b_pass0_plan", 32'(pass0), 32'h8);
    idle("t3b", 1);

    // Two channels fail together; short-window instance saturates at 3.
    step("t4", 1'b1, 4'b0101, 4'b0000);
    idle("t4", 8);
    check("t4_fail0_plan", 32'(fail0), 32'h5);
    check("t4_err0_plan", 32'(err0), 32'd3);
    check("t4_err1_sat", 32'(err1), 32'd3);
    idle("t4", 1);

    // a held high with b low: back-to-back fails, no restart from extra a.
    for (int k = 0; k < 30; k++) step("t5", 1'b1, 4'b0010, 4'b0000);
    idle("t5", 9);

    // a and b together on the trigger edge: b is not a response.
    step("t6", 1'b1, 4'b0001, 4'b0001);
    idle("t6", 9);

    // en dropped mid-attempt.
    step("t7", 1'b1, 4'b0011, 4'b0000);
    idle("t7", 2);
    step("t7", 1'b0, 4'b0000, 4'b0000);
    check("t7_busy0_plan", 32'(busy0), 32'h0);
    step("t7", 1'b0, 4'b0011, 4'b0011);
    idle("t7", 3);

    // Reset with an attempt open at delay 4.
    step("t8", 1'b1, 4'b0001, 4'b0000);
    idle("t8", 3);
    async_reset("t8_rst");
    idle("t8", 10);

    // Randomised traffic with occasional enable drops and resets.
    for (int c = 0; c < 600; c++) begin
      for (int j = 0; j < 4; j++) begin
        ra[j] = ($urandom_range(0, 3) == 0);
        rb[j] = ($urandom_range(0, 4) == 0);
      end
      ren = ($urandom_range(0, 24) != 0);
      step("rnd", ren, ra, rb);
      if (c % 200 == 150) async_reset("rnd_rst");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
